// File: rtl/seg_capture_pkg.sv
// seg_capture_pkg: shared tracker states and the active-low hex glyph table.
package seg_capture_pkg;
   typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   // Segment order {a,b,c,d,e,f,g}, active-low; entry i is the glyph for hex value i.
   localparam logic [6:0] SEG_GLYPH [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };
endpackage

// File: rtl/seg_capture_seg2bin.sv
// seg2bin: combinational decode of an active-low 7-segment pattern to hex.
module seg2bin
   import seg_capture_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] bin,
   output logic       hit,
   output logic       blank
);
   always_comb begin
      bin = '0;
      hit = 1'b0;
      for (int i = 0; i < 16; i++)
         if (seg == SEG_GLYPH[i]) begin
            bin = 4'(i);
            hit = 1'b1;
         end
      blank = seg == SEG_BLANK;
   end
endmodule

// File: rtl/seg_capture.sv
// seg_capture: debounces a multiplexed common-anode 7-segment bus and stores
// the decoded hex value of each digit position once its pattern is stable.
module seg_capture
   import seg_capture_pkg::*;
#(
   parameter int N_DIGITS   = 8,
   parameter int STABLE_CNT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [6:0]            seg,
   input  logic [N_DIGITS-1:0]   anode,
   output logic [4*N_DIGITS-1:0] digits,
   output logic [N_DIGITS-1:0]   valid,
   output logic                  upd,
   output logic                  err
);
   localparam int KW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;

   state_t                state, state_n;
   logic [7:0]            cnt, cnt_n;
   logic [KW-1:0]         prev_k, prev_k_n, k;
   logic [6:0]            prev_seg, prev_seg_n;
   logic [N_DIGITS-1:0]   sel, valid_n;
   logic [4*N_DIGITS-1:0] digits_n;
   logic [3:0]            bin;
   logic                  legal, same, cap, hit, blank, upd_n, err_n;

   assign sel   = ~anode;
   assign legal = |sel && ~|(sel & (sel - 1'b1));
   assign same  = k == prev_k && seg == prev_seg;

   always_comb begin
      k = '0;
      for (int i = 0; i < N_DIGITS; i++)
         if (sel[i]) k = KW'(i);
   end

   // Capture always fires on a sample equal to the new prev_*, so decoding the live seg is exact.
   seg2bin u_dec (.seg(seg), .bin(bin), .hit(hit), .blank(blank));

   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      prev_k_n   = prev_k;
      prev_seg_n = prev_seg;
      cap        = 1'b0;
      if (en && !legal) begin
         state_n = IDLE;
         cnt_n   = '0;
      end else if (en && (state == IDLE || !same)) begin
         prev_k_n   = k;
         prev_seg_n = seg;
         cnt_n      = 8'd1;
         cap        = STABLE_CNT == 1;
         state_n    = cap ? HOLD : TRACK;
      end else if (en && state == TRACK) begin
         cnt_n   = cnt + 8'd1;
         cap     = cnt_n == 8'(STABLE_CNT);
         state_n = cap ? HOLD : TRACK;
      end
   end

   always_comb begin
      digits_n = digits;
      valid_n  = valid;
      upd_n    = 1'b0;
      err_n    = 1'b0;
      if (cap) begin
         upd_n      = hit ? (!valid[k] || digits[k*4 +: 4] != bin) : (blank && valid[k]);
         err_n      = !hit && !blank;
         valid_n[k] = hit;
         if (hit) digits_n[k*4 +: 4] = bin;
      end
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         prev_k   <= '0;
         prev_seg <= SEG_BLANK;
         digits   <= '0;
         valid    <= '0;
         upd      <= 1'b0;
         err      <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         prev_k   <= prev_k_n;
         prev_seg <= prev_seg_n;
         digits   <= digits_n;
         valid    <= valid_n;
         upd      <= upd_n;
         err      <= err_n;
      end
endmodule

// File: tb/tb_seg_capture.sv
// tb_seg_capture: directed stimulus with a scoreboard of expected upd/err events.
module tb_seg_capture;
   typedef struct {
      logic        upd;
      logic        err;
      logic [31:0] dig;
      logic [7:0]  val;
   } ev_t;

   logic        clk = 1'b0, rst = 1'b1, en = 1'b0;
   logic [6:0]  seg = 7'h7F;
   logic [7:0]  anode = 8'hFF;
   logic [31:0] digits;
   logic [7:0]  valid;
   logic        upd, err;

   logic [6:0]  g [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };

   ev_t         q[$];
   logic [31:0] m_dig = '0;
   logic [7:0]  m_val = '0;
   int          passed = 0, total = 0;

   seg_capture #(.N_DIGITS(8), .STABLE_CNT(4)) dut (
      .clk(clk), .rst(rst), .en(en), .seg(seg), .anode(anode),
      .digits(digits), .valid(valid), .upd(upd), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic sample();
      ev_t e;
      if (upd || err) begin
         if (q.size() == 0) check("unexpected_event", {upd, err}, 2'b00);
         else begin
            e = q.pop_front();
            check("ev_upd", upd, e.upd);
            check("ev_err", err, e.err);
            check("ev_digits", digits, e.dig);
            check("ev_valid", valid, e.val);
         end
      end
   endtask

   task automatic strobe(input logic [7:0] an, input logic [6:0] sg, input int gap = 0);
      @(negedge clk);
      en = 1'b1; anode = an; seg = sg;
      @(posedge clk);
      #1;
      en = 1'b0;
      sample();
      repeat (gap) begin
         @(posedge clk);
         #1;
         sample();
      end
   endtask

   task automatic rep(input logic [7:0] an, input logic [6:0] sg, input int n);
      for (int i = 0; i < n; i++) strobe(an, sg);
   endtask

   function automatic logic [7:0] pos(input int p);
      logic [7:0] a = 8'hFF;
      a[p] = 1'b0;
      return a;
   endfunction

   task automatic push_hex(input int k, input logic [3:0] v);
      logic u;
      u = !m_val[k] || m_dig[k*4 +: 4] != v;
      m_dig[k*4 +: 4] = v;
      m_val[k] = 1'b1;
      if (u) q.push_back('{1'b1, 1'b0, m_dig, m_val});
   endtask

   task automatic push_blank(input int k);
      logic u;
      u = m_val[k];
      m_val[k] = 1'b0;
      if (u) q.push_back('{1'b1, 1'b0, m_dig, m_val});
   endtask

   task automatic push_bad(input int k);
      m_val[k] = 1'b0;
      q.push_back('{1'b0, 1'b1, m_dig, m_val});
   endtask

   task automatic state_check(input string tag);
      check({tag, "_pending"}, q.size(), 0);
      check({tag, "_digits"}, digits, m_dig);
      check({tag, "_valid"}, valid, m_val);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rst_digits", digits, 0);
      check("rst_valid", valid, 0);
      check("rst_upd", upd, 0);
      check("rst_err", err, 0);
      @(negedge clk);
      rst = 1'b0;

      // first capture, with idle gaps between strobes
      for (int i = 0; i < 3; i++) strobe(8'b1111_1110, 7'b0000110, 3);
      push_hex(0, 4'h3);
      strobe(8'b1111_1110, 7'b0000110, 2);
      check("first_digit", digits[3:0], 4'h3);
      check("first_valid", valid, 8'h01);
      rep(8'b1111_1110, 7'b0000110, 3);
      state_check("hold");

      // interrupted window: only the second pattern is captured
      rep(pos(1), g[5], 3);
      rep(pos(1), g[6], 3);
      state_check("interrupt");
      push_hex(1, 4'h6);
      strobe(pos(1), g[6]);
      state_check("second");

      // two sweeps over all positions with every glyph
      for (int s = 0; s < 2; s++)
         for (int p = 0; p < 8; p++) begin
            rep(pos(p), g[s*8+p], 3);
            push_hex(p, 4'(s*8+p));
            strobe(pos(p), g[s*8+p]);
         end
      state_check("sweep");

      // illegal glyph, then blank on a valid position
      rep(pos(2), 7'b1111110, 3);
      push_bad(2);
      strobe(pos(2), 7'b1111110);
      check("bad_valid2", valid[2], 1'b0);
      rep(pos(3), 7'h7F, 3);
      push_blank(3);
      strobe(pos(3), 7'h7F);
      state_check("blank");

      // blanking interval and double anode restart the count
      rep(pos(4), g[1], 2);
      strobe(8'hFF, g[1]);
      rep(pos(4), g[1], 3);
      state_check("blanking");
      strobe(8'b1110_1110, g[1]);
      rep(pos(4), g[1], 3);
      state_check("double");
      push_hex(4, 4'h1);
      strobe(pos(4), g[1]);
      state_check("restart");

      // asynchronous reset mid-count
      rep(pos(5), g[10], 2);
      #3;
      rst = 1'b1;
      #1;
      m_dig = '0;
      m_val = '0;
      check("arst_digits", digits, 0);
      check("arst_valid", valid, 0);
      check("arst_upd", upd, 0);
      check("arst_err", err, 0);
      @(negedge clk);
      rst = 1'b0;
      rep(pos(5), g[10], 3);
      state_check("post_rst");
      push_hex(5, 4'hA);
      strobe(pos(5), g[10]);
      repeat (2) strobe(8'hFF, 7'h7F);
      state_check("final");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
